// File: rtl/magic_button_ctl_pkg.sv
// Shared types and helpers for the front-panel magic button controller.
package magic_button_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_REL,
        LONG,
        LOCKED
    } magic_btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF  = 280000;
    localparam int unsigned LONGPRESS_CYCLES_DEF = 56000000;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/magic_button_ctl_if.sv
// Request/acknowledge bundle between the button conditioner and the magic block.
interface magic_button_ctl_if;

    logic magic_mode;
    logic magic_button;
    logic pressed;
    logic reset_req;

    modport master (
        input  magic_mode,
        output magic_button,
        output pressed,
        output reset_req
    );

    modport slave (
        output magic_mode,
        input  magic_button,
        input  pressed,
        input  reset_req
    );

endinterface

// File: rtl/magic_button_ctl_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low panel button.
// Reusable for any front-panel button; level is 1 while the button is held.
module debounce
    import magic_button_ctl_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk28,
    input  logic rst,
    input  logic n_in,
    output logic level
);

    localparam int unsigned CW = cnt_w(CYCLES);

    logic          sync_p0;
    logic          sync_p1;
    logic          sync_p;
    logic [CW-1:0] cnt;

    assign sync_p = ~sync_p1;

    // Synchroniser idles at "released" so a held button must debounce afresh after reset.
    always_ff @(posedge clk28) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= n_in;
            sync_p1 <= sync_p0;
            if (sync_p == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= sync_p;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/magic_button_ctl.sv
// Conditions the raw MAGIC pin into a latched request for the magic NMI block.
// Optional long-press reset pulse is built only when MAGIC_LONGPRESS_RESET_EN is defined.
module magic_button_ctl
    import magic_button_ctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONGPRESS_CYCLES = LONGPRESS_CYCLES_DEF
) (
    input  logic                 clk28,
    input  logic                 rst,
    input  logic                 n_magic,
    magic_button_ctl_if.master   btn
);

    logic             pressed;
    logic             pressed_p1;
    logic             press_evt;
    logic             magic_button_p1;
    magic_btn_state_t state;
    magic_btn_state_t state_nxt;

    debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk28 (clk28),
        .rst   (rst),
        .n_in  (n_magic),
        .level (pressed)
    );

    assign press_evt = pressed & ~pressed_p1;

`ifdef MAGIC_LONGPRESS_RESET_EN
    localparam int unsigned HW = cnt_w(LONGPRESS_CYCLES);

    logic [HW-1:0] hold_cnt;
    logic          hold_hit;
    logic          reset_req_p1;

    assign hold_hit = (hold_cnt == HW'(LONGPRESS_CYCLES - 1));

    // Counts only while a request is live; parks at the threshold until release.
    always_ff @(posedge clk28) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (!pressed) begin
            hold_cnt <= '0;
        end else if ((state == REQ || state == WAIT_REL) && !hold_hit) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            reset_req_p1 <= 1'b0;
        end else begin
            reset_req_p1 <= (state_nxt == LONG);
        end
    end

    assign btn.reset_req = reset_req_p1;
`else
    assign btn.reset_req = 1'b0;
`endif

    always_ff @(posedge clk28) begin
        if (rst) begin
            state           <= IDLE;
            pressed_p1      <= 1'b0;
            magic_button_p1 <= 1'b0;
        end else begin
            state           <= state_nxt;
            pressed_p1      <= pressed;
            magic_button_p1 <= (state_nxt == REQ);
        end
    end

    // The long-press threshold outranks the acknowledge in both request states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press_evt) state_nxt = REQ;
            end
            REQ: begin
`ifdef MAGIC_LONGPRESS_RESET_EN
                if (hold_hit) state_nxt = LONG;
                else
`endif
                if (btn.magic_mode) state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
`ifdef MAGIC_LONGPRESS_RESET_EN
                if (hold_hit) state_nxt = LONG;
                else
`endif
                if (!pressed) state_nxt = IDLE;
            end
`ifdef MAGIC_LONGPRESS_RESET_EN
            LONG: begin
                state_nxt = LOCKED;
            end
            LOCKED: begin
                if (!pressed) state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign btn.magic_button = magic_button_p1;
    assign btn.pressed      = pressed;

endmodule

// File: tb/tb_magic_button_ctl.sv
// Directed bench for magic_button_ctl with DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=32.
// Expected {pressed, magic_button, reset_req} per cycle are queued and compared at negedge.
module tb_magic_button_ctl;

    logic clk28 = 1'b0;
    logic rst;
    logic n_magic;

    always #5 clk28 = ~clk28;

    magic_button_ctl_if bus ();

    magic_button_ctl #(
        .DEBOUNCE_CYCLES  (4),
        .LONGPRESS_CYCLES (32)
    ) dut (
        .clk28   (clk28),
        .rst     (rst),
        .n_magic (n_magic),
        .btn     (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] val;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    always @(posedge clk28) cyc <= cyc + 1;

    task automatic expect_win(input int from, input int to, input logic p,
                              input logic m, input logic r, input string tag);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.cyc = c;
            e.val = {p, m, r};
            e.tag = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    // Scoreboard consumer
    initial begin
        int         rd;
        logic [2:0] obs;
        rd = 0;
        forever begin
            @(negedge clk28);
            obs = {bus.pressed, bus.magic_button, bus.reset_req};
            while (rd < exp_q.size() && exp_q[rd].cyc <= cyc) begin
                checks++;
                assert (exp_q[rd].cyc == cyc && obs === exp_q[rd].val) else begin
                    failures++;
                    $error("FAIL %s cyc=%0d observed(pr,mb,rr)=%b expected=%b",
                           exp_q[rd].tag, exp_q[rd].cyc, obs, exp_q[rd].val);
                end
                rd++;
            end
            if (done) begin
                while (rd < exp_q.size()) begin
                    checks++;
                    failures++;
                    $display("FAIL unchecked_%s cyc=%0d observed=none expected=%b",
                             exp_q[rd].tag, exp_q[rd].cyc, exp_q[rd].val);
                    rd++;
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin
        int c0;
        rst            = 1'b1;
        n_magic        = 1'b1;
        bus.magic_mode = 1'b0;
        step(2);
        rst = 1'b0;
        expect_win(cyc, cyc + 3, 1'b0, 1'b0, 1'b0, "reset");
        step(4);

        // press 10 cycles, acknowledge long after release
        c0 = cyc;
        n_magic = 1'b0;
        expect_win(c0,      c0 + 5,  1'b0, 1'b0, 1'b0, "s1_debounce");
        expect_win(c0 + 6,  c0 + 6,  1'b1, 1'b0, 1'b0, "s1_pressed");
        expect_win(c0 + 7,  c0 + 15, 1'b1, 1'b1, 1'b0, "s1_req");
        expect_win(c0 + 16, c0 + 40, 1'b0, 1'b1, 1'b0, "s1_latched");
        expect_win(c0 + 41, c0 + 45, 1'b0, 1'b0, 1'b0, "s2_ack");
        step(10);
        n_magic = 1'b1;
        step(30);
        bus.magic_mode = 1'b1;
        step(2);
        bus.magic_mode = 1'b0;
        step(4);

        // glitches of 3 low cycles every 5 cycles
        c0 = cyc;
        expect_win(c0, c0 + 29, 1'b0, 1'b0, 1'b0, "s3_glitch");
        for (int k = 0; k < 4; k++) begin
            n_magic = 1'b0;
            step(3);
            n_magic = 1'b1;
            step(2);
        end
        step(10);

        // 60-cycle hold
        c0 = cyc;
        n_magic = 1'b0;
        expect_win(c0,     c0 + 5, 1'b0, 1'b0, 1'b0, "s4_debounce");
        expect_win(c0 + 6, c0 + 6, 1'b1, 1'b0, 1'b0, "s4_pressed");
`ifdef MAGIC_LONGPRESS_RESET_EN
        expect_win(c0 + 7,  c0 + 38, 1'b1, 1'b1, 1'b0, "s4_req");
        expect_win(c0 + 39, c0 + 39, 1'b1, 1'b0, 1'b1, "s4_reset_req");
        expect_win(c0 + 40, c0 + 65, 1'b1, 1'b0, 1'b0, "s4_locked");
        expect_win(c0 + 66, c0 + 75, 1'b0, 1'b0, 1'b0, "s4_released");
`else
        expect_win(c0 + 7,  c0 + 65, 1'b1, 1'b1, 1'b0, "s5_req");
        expect_win(c0 + 66, c0 + 70, 1'b0, 1'b1, 1'b0, "s5_latched");
        expect_win(c0 + 71, c0 + 75, 1'b0, 1'b0, 1'b0, "s5_ack");
`endif
        step(60);
        n_magic = 1'b1;
        step(10);
        bus.magic_mode = 1'b1;
        step(2);
        bus.magic_mode = 1'b0;
        step(4);

        // reset pulse while in REQ with the pin still held
        c0 = cyc;
        n_magic = 1'b0;
        expect_win(c0,      c0 + 5,  1'b0, 1'b0, 1'b0, "s6_debounce");
        expect_win(c0 + 6,  c0 + 6,  1'b1, 1'b0, 1'b0, "s6_pressed");
        expect_win(c0 + 7,  c0 + 10, 1'b1, 1'b1, 1'b0, "s6_req");
        expect_win(c0 + 11, c0 + 16, 1'b0, 1'b0, 1'b0, "s6_reset");
        expect_win(c0 + 17, c0 + 17, 1'b1, 1'b0, 1'b0, "s6_repressed");
        expect_win(c0 + 18, c0 + 25, 1'b1, 1'b1, 1'b0, "s6_new_req");
        expect_win(c0 + 26, c0 + 30, 1'b0, 1'b1, 1'b0, "s6_latched");
        expect_win(c0 + 31, c0 + 34, 1'b0, 1'b0, 1'b0, "s6_ack");
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(9);
        n_magic = 1'b1;
        step(10);
        bus.magic_mode = 1'b1;
        step(2);
        bus.magic_mode = 1'b0;
        step(3);

        // acknowledge already high when the press is accepted
        c0 = cyc;
        bus.magic_mode = 1'b1;
        n_magic = 1'b0;
        expect_win(c0,      c0 + 5,  1'b0, 1'b0, 1'b0, "s7_debounce");
        expect_win(c0 + 6,  c0 + 6,  1'b1, 1'b0, 1'b0, "s7_pressed");
        expect_win(c0 + 7,  c0 + 7,  1'b1, 1'b1, 1'b0, "s7_one_cycle_req");
        expect_win(c0 + 8,  c0 + 13, 1'b1, 1'b0, 1'b0, "s7_wait_rel");
        expect_win(c0 + 14, c0 + 18, 1'b0, 1'b0, 1'b0, "s7_idle");
        step(8);
        n_magic = 1'b1;
        step(8);
        bus.magic_mode = 1'b0;
        step(3);

        done = 1'b1;
        step(20);
        $display("FAIL watchdog cyc=%0d observed=no_summary expected=summary", cyc);
        $fatal(1, "bench did not reach its summary");
    end

endmodule
